mem_access_ctrl: RTL and testbench

- Multi-cycle access controller between the EX/MEM pipeline register and the data memory.
- Accepts the MEM-stage read/write request (ALU result address, Rm store value) and checks the address against the data-memory window.
- Drives the data memory with wait states, freezing the pipeline until the access completes.
- Captures read data for the MEM/WB register.

---
 rtl/mem_access_ctrl_if.sv | 27 ++
 rtl/mem_access_ctrl.sv | 94 +++++++++
 tb/tb_mem_access_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Bus bundle between the MEM stage, the access controller and the data memory.
// The controller owns the slave modport; the pipeline/memory side owns master.
interface mem_access_ctrl_if;
   logic        mem_r_en;
   logic        mem_w_en;
   logic [31:0] alu_res;
   logic [31:0] val_rm;
   logic [31:0] dm_rd_data;
   logic        dm_r_en;
   logic        dm_w_en;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        addr_fault;
   logic        freeze;

   modport master (
      output mem_r_en, mem_w_en, alu_res, val_rm, dm_rd_data,
      input  dm_r_en, dm_w_en, dm_addr, dm_wdata, rdata, ready, addr_fault, freeze
   );

   modport slave (
      input  mem_r_en, mem_w_en, alu_res, val_rm, dm_rd_data,
      output dm_r_en, dm_w_en, dm_addr, dm_wdata, rdata, ready, addr_fault, freeze
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Multi-cycle data-memory access controller: window check, wait-stated strobe,
// pipeline freeze and load-data capture for the MEM/WB register.
module mem_access_ctrl #(
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input logic              clk,
   input logic              rst,
   mem_access_ctrl_if.slave bus
);

   localparam logic [31:0] EndAddr = BASE_ADDR + 32'(4 * DEPTH);
   localparam logic [3:0]  CntInit = 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic        op_write_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        ready_q;
   logic        fault_q;
   logic        req;
   logic        fault;
   logic        strobe;

   assign req   = bus.mem_r_en | bus.mem_w_en;
   assign fault = (bus.alu_res < BASE_ADDR) || (bus.alu_res >= EndAddr) ||
                  (bus.alu_res[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         cnt_q      <= 4'd0;
         op_write_q <= 1'b0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         rdata_q    <= 32'd0;
         ready_q    <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req) begin
                  addr_q     <= bus.alu_res;
                  wdata_q    <= bus.val_rm;
                  op_write_q <= bus.mem_w_en;  // write wins when both are requested
                  if (fault) begin
                     state_q <= StDone;
                     ready_q <= 1'b1;
                     fault_q <= 1'b1;
                     if (!bus.mem_w_en) rdata_q <= 32'd0;
                  end else begin
                     state_q <= StBusy;
                     cnt_q   <= CntInit;
                     fault_q <= 1'b0;
                  end
               end
            end
            StBusy: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  if (!op_write_q) rdata_q <= bus.dm_rd_data;
                  state_q <= StDone;
                  ready_q <= 1'b1;
               end
            end
            StDone: begin
               // A request seen here belongs to the instruction just completed.
               state_q <= StIdle;
               fault_q <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign strobe = rst && (state_q == StBusy) && (cnt_q == 4'd0);

   assign bus.dm_r_en    = strobe & ~op_write_q;
   assign bus.dm_w_en    = strobe & op_write_q;
   assign bus.dm_addr    = addr_q;
   assign bus.dm_wdata   = wdata_q;
   assign bus.rdata      = rdata_q;
   assign bus.ready      = ready_q;
   assign bus.addr_fault = fault_q;
   assign bus.freeze     = rst && (((state_q == StIdle) && req) || (state_q == StBusy));

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: table of single accesses plus hand-written
// sequences for held requests and reset during an access.
module tb_mem_access_ctrl;

   localparam logic [31:0] Base = 32'd1024;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_access_ctrl_if bus ();

   mem_access_ctrl #(
      .BASE_ADDR  (Base),
      .DEPTH      (64),
      .WAIT_CYCLES(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Data memory model: combinational read, write commits on the strobed edge.
   logic [31:0] mem [64];
   logic [31:0] off;
   assign off = bus.dm_addr - Base;

   function automatic logic [31:0] init_val(input int i);
      case (i)
         0:       return 32'd9;
         11:      return 32'd10;
         63:      return 32'h77;
         default: return 32'h1000 + 32'(i);
      endcase
   endfunction

   always_comb begin
      bus.dm_rd_data = 32'hBAD0_BAD0;
      if (bus.dm_addr >= Base && bus.dm_addr < Base + 32'd256) bus.dm_rd_data = mem[off[7:2]];
   end

   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
      end else if (bus.dm_w_en) begin
         mem[off[7:2]] <= bus.dm_wdata;
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   logic [15:0] obs_frz, obs_rs, obs_ws, obs_rdy, obs_flt;

   task automatic clear_obs();
      obs_frz = '0; obs_rs = '0; obs_ws = '0; obs_rdy = '0; obs_flt = '0;
   endtask

   task automatic record(input int c);
      obs_frz[c] = bus.freeze;
      obs_rs[c]  = bus.dm_r_en;
      obs_ws[c]  = bus.dm_w_en;
      obs_rdy[c] = bus.ready;
      obs_flt[c] = bus.addr_fault;
   endtask

   typedef struct {
      logic        r;
      logic        w;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [7:0]  e_frz;
      logic [7:0]  e_rs;
      logic [7:0]  e_ws;
      logic [7:0]  e_rdy;
      logic [7:0]  e_flt;
      logic [31:0] e_rdata;
   } vec_t;

   // Entered and left at posedge+1; request is presented in cycle 0 only.
   task automatic run_vec(input string tag, input vec_t v);
      clear_obs();
      for (int c = 0; c < 8; c++) begin
         if (c == 0) begin
            bus.mem_r_en = v.r; bus.mem_w_en = v.w; bus.alu_res = v.addr; bus.val_rm = v.wdata;
         end else begin
            bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0;
         end
         @(negedge clk);
         record(c);
         @(posedge clk);
         #1;
      end
      check({tag, "_freeze"},  32'(obs_frz[7:0]), 32'(v.e_frz));
      check({tag, "_rstrobe"}, 32'(obs_rs[7:0]),  32'(v.e_rs));
      check({tag, "_wstrobe"}, 32'(obs_ws[7:0]),  32'(v.e_ws));
      check({tag, "_ready"},   32'(obs_rdy[7:0]), 32'(v.e_rdy));
      check({tag, "_fault"},   32'(obs_flt[7:0]), 32'(v.e_flt));
      check({tag, "_rdata"},   bus.rdata,    v.e_rdata);
      check({tag, "_dm_addr"}, bus.dm_addr,  v.addr);
      check({tag, "_dm_wdata"}, bus.dm_wdata, v.wdata);
   endtask

   vec_t vecs [11];
   vec_t v_rst;
   vec_t v_post;

   initial begin
      //            r     w     addr          wdata         frz    rs     ws     rdy    flt    rdata
      vecs[0]  = '{1'b0, 1'b1, 32'h428, 32'hDEADBEEF, 8'h07, 8'h00, 8'h04, 8'h08, 8'h00, 32'h0};
      vecs[1]  = '{1'b1, 1'b0, 32'h400, 32'h0,        8'h07, 8'h04, 8'h00, 8'h08, 8'h00, 32'd9};
      vecs[2]  = '{1'b1, 1'b0, 32'h3FC, 32'h0,        8'h01, 8'h00, 8'h00, 8'h02, 8'h02, 32'h0};
      vecs[3]  = '{1'b1, 1'b0, 32'h402, 32'h0,        8'h01, 8'h00, 8'h00, 8'h02, 8'h02, 32'h0};
      vecs[4]  = '{1'b1, 1'b0, 32'h4FC, 32'h0,        8'h07, 8'h04, 8'h00, 8'h08, 8'h00, 32'h77};
      vecs[5]  = '{1'b1, 1'b0, 32'h500, 32'h0,        8'h01, 8'h00, 8'h00, 8'h02, 8'h02, 32'h0};
      vecs[6]  = '{1'b1, 1'b0, 32'h404, 32'h0,        8'h07, 8'h04, 8'h00, 8'h08, 8'h00, 32'h11};
      vecs[7]  = '{1'b0, 1'b1, 32'h3FC, 32'hAA,       8'h01, 8'h00, 8'h00, 8'h02, 8'h02, 32'h11};
      vecs[8]  = '{1'b1, 1'b1, 32'h404, 32'h5,        8'h07, 8'h00, 8'h04, 8'h08, 8'h00, 32'h11};
      vecs[9]  = '{1'b1, 1'b0, 32'h404, 32'h0,        8'h07, 8'h04, 8'h00, 8'h08, 8'h00, 32'h5};
      vecs[10] = '{1'b1, 1'b0, 32'h428, 32'h0,        8'h07, 8'h04, 8'h00, 8'h08, 8'h00, 32'hDEADBEEF};
      v_rst    = '{1'b0, 1'b1, 32'h404, 32'h11,       8'h07, 8'h00, 8'h04, 8'h08, 8'h00, 32'h0};
      v_post   = '{1'b1, 1'b0, 32'h404, 32'h0,        8'h07, 8'h04, 8'h00, 8'h08, 8'h00, 32'h1001};

      // Reset held for two edges with a write request pending.
      rst = 1'b0;
      bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b1; bus.alu_res = 32'h404; bus.val_rm = 32'h11;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_freeze",   32'(bus.freeze),     32'd0);
      check("rst_strobes",  32'({bus.dm_r_en, bus.dm_w_en}), 32'd0);
      check("rst_ready",    32'(bus.ready),      32'd0);
      check("rst_fault",    32'(bus.addr_fault), 32'd0);
      check("rst_rdata",    bus.rdata,           32'd0);
      check("rst_dm_addr",  bus.dm_addr,         32'd0);
      check("rst_dm_wdata", bus.dm_wdata,        32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      run_vec("rst_release", v_rst);

      for (int i = 0; i < 11; i++) run_vec($sformatf("v%0d", i), vecs[i]);

      // Read held through DONE must not be re-accepted; next read follows in cycle 4.
      clear_obs();
      bus.mem_r_en = 1'b1; bus.mem_w_en = 1'b0; bus.alu_res = 32'h400; bus.val_rm = 32'h0;
      for (int c = 0; c < 10; c++) begin
         if (c == 4) bus.alu_res = 32'h42C;
         if (c == 5) bus.mem_r_en = 1'b0;
         @(negedge clk);
         record(c);
         if (c == 3) check("hold_rdata_c3", bus.rdata, 32'd9);
         @(posedge clk);
         #1;
      end
      check("hold_freeze",  32'(obs_frz), 32'h0077);
      check("hold_rstrobe", 32'(obs_rs),  32'h0044);
      check("hold_wstrobe", 32'(obs_ws),  32'h0000);
      check("hold_ready",   32'(obs_rdy), 32'h0088);
      check("hold_rdata",   bus.rdata,    32'd10);
      check("hold_dm_addr", bus.dm_addr,  32'h42C);

      // Reset during BUSY abandons the write.
      clear_obs();
      bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b1; bus.alu_res = 32'h408; bus.val_rm = 32'h99;
      for (int c = 0; c < 8; c++) begin
         if (c == 1) begin
            rst = 1'b0;
            bus.mem_w_en = 1'b0;
         end
         if (c == 2) rst = 1'b1;
         @(negedge clk);
         record(c);
         @(posedge clk);
         #1;
      end
      check("busyrst_freeze",  32'(obs_frz), 32'h0001);
      check("busyrst_wstrobe", 32'(obs_ws),  32'h0000);
      check("busyrst_rstrobe", 32'(obs_rs),  32'h0000);
      check("busyrst_ready",   32'(obs_rdy), 32'h0000);
      check("busyrst_dm_addr", bus.dm_addr,  32'h0);
      run_vec("post_rst", v_post);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
